mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between two cores, the memory arbiter and the shared RAM.
// The arbiter uses the slave modport; the core/RAM side uses the master modport.
interface mem_arbiter_if #(
    parameter int unsigned WORD_W = 32
);
    logic [1:0]             iREN;
    logic [1:0][WORD_W-1:0] iaddr;
    logic [1:0]             dREN;
    logic [1:0]             dWEN;
    logic [1:0][WORD_W-1:0] daddr;
    logic [1:0][WORD_W-1:0] dstore;
    logic [1:0]             iwait;
    logic [1:0]             dwait;
    logic [1:0][WORD_W-1:0] iload;
    logic [1:0][WORD_W-1:0] dload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic                   arb_err;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-core instruction/data arbiter in front of a single RAM port.
// Optional watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] RamAccess = 2'd2;

    typedef enum logic {StIdle, StServe} state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic       r_cls;  // 1: data class, 0: instruction class
    logic       w_cls_nxt;
    logic       r_core;
    logic       w_core_nxt;
    logic       r_ptr_i;
    logic       w_ptr_i_nxt;
    logic       r_ptr_d;
    logic       w_ptr_d_nxt;
    logic [1:0] w_dreq;
    logic       w_live;
    logic       w_access;
    logic       w_timeout;

    assign w_dreq   = bus.dREN | bus.dWEN;
    assign w_live   = r_cls ? w_dreq[r_core] : bus.iREN[r_core];
    assign w_access = (r_state == StServe) && w_live && (bus.ramstate == RamAccess);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_cls   <= 1'b0;
            r_core  <= 1'b0;
            r_ptr_i <= 1'b0;
            r_ptr_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cls   <= w_cls_nxt;
            r_core  <= w_core_nxt;
            r_ptr_i <= w_ptr_i_nxt;
            r_ptr_d <= w_ptr_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cls_nxt   = r_cls;
        w_core_nxt  = r_core;
        w_ptr_i_nxt = r_ptr_i;
        w_ptr_d_nxt = r_ptr_d;
        case (r_state)
            StIdle: begin
                // Data beats instruction; inside a class the pointer core wins if it asks.
                if (|w_dreq) begin
                    w_state_nxt = StServe;
                    w_cls_nxt   = 1'b1;
                    w_core_nxt  = w_dreq[r_ptr_d] ? r_ptr_d : ~r_ptr_d;
                end else if (|bus.iREN) begin
                    w_state_nxt = StServe;
                    w_cls_nxt   = 1'b0;
                    w_core_nxt  = bus.iREN[r_ptr_i] ? r_ptr_i : ~r_ptr_i;
                end
            end
            StServe: begin
                if (!w_live) begin
                    w_state_nxt = StIdle;
                end else if (w_access || w_timeout) begin
                    w_state_nxt = StIdle;
                    if (r_cls) w_ptr_d_nxt = ~r_ptr_d;
                    else       w_ptr_i_nxt = ~r_ptr_i;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        bus.iwait    = 2'b11;
        bus.dwait    = 2'b11;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (r_state == StServe) begin
            if (r_cls) begin
                bus.ramaddr         = bus.daddr[r_core];
                bus.ramstore        = bus.dstore[r_core];
                bus.ramWEN          = bus.dWEN[r_core];
                bus.ramREN          = bus.dREN[r_core] & ~bus.dWEN[r_core];
                bus.dload[r_core]   = bus.ramload;
                if (w_access) bus.dwait[r_core] = 1'b0;
            end else begin
                bus.ramaddr         = bus.iaddr[r_core];
                bus.ramREN          = bus.iREN[r_core];
                bus.iload[r_core]   = bus.ramload;
                if (w_access) bus.iwait[r_core] = 1'b0;
            end
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] r_cnt;
    logic            r_err;

    // Fires on the TIMEOUT_CYC-th consecutive SERVE cycle still waiting on the RAM.
    assign w_timeout = (r_state == StServe) && w_live && (bus.ramstate != RamAccess)
                       && (r_cnt == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= ((r_state == StServe) && (w_state_nxt == StServe)) ? r_cnt + 1'b1 : '0;
            r_err <= r_err | w_timeout;
        end
    end

    assign bus.arb_err = r_err;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
    assign w_timeout            = 1'b0;
    assign bus.arb_err          = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle reference model plus directed scenarios.
// Build with MEM_ARBITER_TIMEOUT_EN defined to exercise the watchdog scenario.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.WORD_W(W)) bus ();

    mem_arbiter #(
        .WORD_W     (W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: current grant (-1 none, else class*2+core), per-class pointers.
    int m_g      = -1;
    int m_ptr[2] = '{0, 0};
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    always @(negedge clk) begin : cmp
        logic [1:0]        e_iw, e_dw, dreq;
        logic [1:0][W-1:0] e_il, e_dl;
        logic              e_ren, e_wen;
        logic [W-1:0]      e_addr, e_st;
        int                cls, core, win;
        bit                live, acc;
        e_iw = 2'b11; e_dw = 2'b11; e_il = '0; e_dl = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_st = '0;
        dreq = bus.dREN | bus.dWEN;
        live = 1'b0; acc = 1'b0; cls = 0; core = 0;
        if (!rst && m_g >= 0) begin
            cls  = m_g / 2;
            core = m_g % 2;
            if (cls == 1) begin
                live        = dreq[core];
                e_wen       = bus.dWEN[core];
                e_ren       = bus.dREN[core] & ~bus.dWEN[core];
                e_addr      = bus.daddr[core];
                e_st        = bus.dstore[core];
                e_dl[core]  = bus.ramload;
            end else begin
                live        = bus.iREN[core];
                e_ren       = bus.iREN[core];
                e_addr      = bus.iaddr[core];
                e_il[core]  = bus.ramload;
            end
            acc = live && (bus.ramstate == RS_ACCESS);
            if (acc) begin
                if (cls == 1) e_dw[core] = 1'b0;
                else          e_iw[core] = 1'b0;
            end
        end
        check("m_iwait",    bus.iwait,    e_iw);
        check("m_dwait",    bus.dwait,    e_dw);
        check("m_iload",    bus.iload,    e_il);
        check("m_dload",    bus.dload,    e_dl);
        check("m_ramREN",   bus.ramREN,   e_ren);
        check("m_ramWEN",   bus.ramWEN,   e_wen);
        check("m_ramaddr",  bus.ramaddr,  e_addr);
        check("m_ramstore", bus.ramstore, e_st);
        check("m_arb_err",  bus.arb_err,  rst ? 1'b0 : m_err);
        if (rst) begin
            m_g = -1; m_ptr[0] = 0; m_ptr[1] = 0; m_err = 1'b0; m_cnt = 0;
        end else if (m_g < 0) begin
            win = -1;
            if (dreq != 2'b00)          win = 2 + (dreq[m_ptr[1]] ? m_ptr[1] : 1 - m_ptr[1]);
            else if (bus.iREN != 2'b00) win = bus.iREN[m_ptr[0]] ? m_ptr[0] : 1 - m_ptr[0];
            m_g   = win;
            m_cnt = 0;
        end else if (!live) begin
            m_g = -1;
        end else if (acc) begin
            m_ptr[cls] = 1 - m_ptr[cls];
            m_g        = -1;
        end else begin
`ifdef MEM_ARBITER_TIMEOUT_EN
            m_cnt++;
            if (m_cnt == TO) begin
                m_err      = 1'b1;
                m_ptr[cls] = 1 - m_ptr[cls];
                m_g        = -1;
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int           ren_cnt, lo_cnt, err_at;
        logic [W-1:0] got;
        logic [1:0]   exp_seq [8];
        logic         ren_k9;
        bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = RS_FREE;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iwait",   bus.iwait,   2'b11);
        check("rst_dwait",   bus.dwait,   2'b11);
        check("rst_loads",   {bus.iload, bus.dload}, 64'h0);
        check("rst_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
        check("rst_err",     bus.arb_err, 1'b0);
        rst = 1'b0;

        // Data read of core 1 with three stall cycles (one reported as ERROR).
        bus.dREN = 2'b10; bus.daddr[1] = 32'h40; bus.ramload = 32'hDEADBEEF;
        bus.ramstate = RS_BUSY;
        ren_cnt = 0; lo_cnt = 0; got = '0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) bus.ramstate = RS_ERROR;
            if (k == 3) bus.ramstate = RS_BUSY;
            if (k == 4) bus.ramstate = RS_ACCESS;
            if (k == 5) begin bus.dREN = 2'b00; bus.ramstate = RS_FREE; end
            @(negedge clk);
            if (bus.ramREN) ren_cnt++;
            if (!bus.dwait[1]) begin lo_cnt++; got = bus.dload[1]; end
            if (k == 4) check("t1_ramaddr", bus.ramaddr, 32'h40);
            tick();
        end
        check("t1_ren_cycles", ren_cnt, 4);
        check("t1_dwait_low",  lo_cnt,  1);
        check("t1_dload",      got,     32'hDEADBEEF);

        // Instruction read and data write (plus read) from core 0 together: write first.
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h100;
        bus.dWEN = 2'b01; bus.dREN = 2'b01; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'h12345678;
        bus.ramstate = RS_ACCESS; bus.ramload = 32'hCAFEF00D;
        @(negedge clk);
        check("t2_idle_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
        tick();
        @(negedge clk);
        check("t2_wr_strobes", {bus.ramREN, bus.ramWEN}, 2'b01);
        check("t2_wr_store",   bus.ramstore, 32'h12345678);
        check("t2_wr_waits",   {bus.iwait, bus.dwait}, 4'b1110);
        tick();
        bus.dWEN = 2'b00; bus.dREN = 2'b00;
        @(negedge clk);
        check("t2_gap", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b001111);
        tick();
        @(negedge clk);
        check("t2_rd_strobes", {bus.ramREN, bus.ramWEN}, 2'b10);
        check("t2_rd_addr",    bus.ramaddr, 32'h100);
        check("t2_rd_iwait",   bus.iwait, 2'b10);
        check("t2_rd_iload",   bus.iload[0], 32'hCAFEF00D);
        tick();
        bus.iREN = 2'b00;

        // Both cores stream data reads: grants alternate 0,1,0,1 two cycles apart.
        exp_seq[0] = 2'b11; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b01;
        exp_seq[4] = 2'b11; exp_seq[5] = 2'b10; exp_seq[6] = 2'b11; exp_seq[7] = 2'b01;
        bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t3_dwait_%0d", k), bus.dwait, exp_seq[k]);
            tick();
        end
        bus.dREN = 2'b00;
        tick();

        // Core 1 instruction request withdrawn mid-serve: abandoned, pointer kept.
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h300; bus.iaddr[0] = 32'h310; bus.ramstate = RS_BUSY;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t4_serve_ren",  bus.ramREN, 1'b1);
        check("t4_serve_addr", bus.ramaddr, 32'h300);
        tick();
        bus.iREN = 2'b00;
        @(negedge clk);
        check("t4_drop_ren",   bus.ramREN, 1'b0);
        check("t4_drop_iwait", bus.iwait, 2'b11);
        tick();
        bus.iREN = 2'b11; bus.ramstate = RS_ACCESS;
        @(negedge clk);
        check("t4_idle_iwait", bus.iwait, 2'b11);
        tick();
        @(negedge clk);
        check("t4_ptr_kept",   bus.iwait, 2'b01);
        check("t4_ptr_addr",   bus.ramaddr, 32'h300);
        tick();
        bus.iREN = 2'b00;

        // Reset during a stalled serve, with the data pointer moved off core 0 first.
        bus.dREN = 2'b01; bus.daddr[0] = 32'h500;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t5_pre_done", bus.dwait, 2'b10);
        tick();
        bus.ramstate = RS_BUSY;
        tick();
        @(negedge clk);
        check("t5_busy_ren", bus.ramREN, 1'b1);
        tick();
        rst = 1'b1;
        bus.dREN = 2'b11;
        #1;
        check("t5_rst_ren",   bus.ramREN, 1'b0);
        check("t5_rst_waits", {bus.iwait, bus.dwait}, 4'b1111);
        check("t5_rst_addr",  bus.ramaddr, 32'h0);
        tick();
        rst = 1'b0;
        bus.ramstate = RS_ACCESS;
        @(negedge clk);
        check("t5_post_idle", bus.dwait, 2'b11);
        tick();
        @(negedge clk);
        check("t5_first_core0", bus.dwait, 2'b10);
        tick();
        bus.dREN = 2'b00;
        tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
        // RAM stuck busy: watchdog fires after TO serve cycles, flag stays until reset.
        bus.dREN = 2'b10; bus.daddr[1] = 32'h600; bus.ramstate = RS_BUSY;
        err_at = -1; ren_k9 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.arb_err && err_at < 0) err_at = k;
            if (k == 9) ren_k9 = bus.ramREN;
            tick();
        end
        check("t6_err_cycle", err_at, 9);
        check("t6_idle_ren",  ren_k9, 1'b0);
        bus.dREN = 2'b00;
        repeat (3) tick();
        check("t6_sticky", bus.arb_err, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_clear", bus.arb_err, 1'b0);
        tick();
        rst = 1'b0;
`else
        // No watchdog: a busy RAM holds the grant indefinitely.
        bus.dREN = 2'b10; bus.daddr[1] = 32'h600; bus.ramstate = RS_BUSY;
        ren_cnt = 0; err_at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.ramREN) ren_cnt++;
            if (bus.arb_err && err_at < 0) err_at = k;
            tick();
        end
        check("t6_held_ren", ren_cnt, 19);
        check("t6_no_err",   err_at, -1);
        bus.ramstate = RS_ACCESS;
        @(negedge clk);
        check("t6_late_done", bus.dwait, 2'b01);
        tick();
        bus.dREN = 2'b00;
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
